// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) round-robin arbiter in front of a
// single-port memory with fixed read latency. One access in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // last_grant encoding; also identifies the owner of the in-flight access
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // WAIT lasts MEM_LAT-1 cycles: counter is loaded with MEM_LAT-2 and
  // DONE is entered on the cycle the counter reads zero.
  localparam logic [3:0] WAIT_LOAD = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic       grant_s;
  logic       sel_d_s;

  // State, latency counter, round-robin pointer and access-type registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= GRANT_I;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
    end
  end

  // Arbitration and next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    we_d    = we_q;
    grant_s = 1'b0;
    sel_d_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_s = 1'b1;
          if (i_req && d_req) begin
            sel_d_s = (last_q == GRANT_I);
          end else begin
            sel_d_s = d_req;
          end
          last_d = sel_d_s ? GRANT_D : GRANT_I;
          we_d   = sel_d_s & d_we;
          // stores complete without waiting for read data
          if ((sel_d_s && d_we) || (MEM_LAT == 1)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory strobe, acks and read-data steering; all forced quiet during reset
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = i_addr;
    mem_wdata = 32'd0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = 32'd0;
    d_rdata   = 32'd0;
    busy      = 1'b0;
    if (!rst) begin
      mem_en = grant_s;
      mem_we = grant_s & sel_d_s & d_we;
      if (sel_d_s) begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_addr  = i_addr;
        mem_wdata = 32'd0;
      end
      busy = (state_q != IDLE);
      if (state_q == DONE) begin
        if (last_q == GRANT_D) begin
          d_ack = 1'b1;
          if (!we_q) begin
            d_rdata = mem_rdata;
          end else begin
            d_rdata = 32'd0;
          end
        end else begin
          i_ack   = 1'b1;
          i_rdata = mem_rdata;
        end
      end else begin
        i_ack = 1'b0;
        d_ack = 1'b0;
      end
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table on a MEM_LAT=2
// instance plus a back-to-back fetch sequence on a MEM_LAT=1 instance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance signals
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [5:0]  i_addr = 6'd0, d_addr = 6'd0, mem_addr;
  logic [31:0] d_wdata = 32'd0, mem_rdata = 32'd0;
  logic        i_ack, d_ack, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_wdata;

  // MEM_LAT=1 instance signals
  logic        u1_rst = 1'b1;
  logic        u1_i_req = 1'b0;
  logic [5:0]  u1_i_addr = 6'd0, u1_mem_addr;
  logic [31:0] u1_mem_rdata = 32'd0;
  logic        u1_i_ack, u1_d_ack, u1_mem_en, u1_mem_we, u1_busy;
  logic [31:0] u1_i_rdata, u1_d_rdata, u1_mem_wdata;

  mem_arbiter #(.ADDR_W(6), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(6), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(u1_rst),
    .i_req(u1_i_req), .i_addr(u1_i_addr), .i_ack(u1_i_ack), .i_rdata(u1_i_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(6'd0), .d_wdata(32'd0),
    .d_ack(u1_d_ack), .d_rdata(u1_d_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr),
    .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata), .busy(u1_busy)
  );

  typedef struct {
    logic        rst;
    logic        ir;
    logic [5:0]  ia;
    logic        dr;
    logic        dw;
    logic [5:0]  da;
    logic [31:0] dwd;
    logic [31:0] mr;
    logic        e_en;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_iack;
    logic        e_dack;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void add(
    input logic rs, input logic ir, input logic [5:0] ia,
    input logic dr, input logic dw, input logic [5:0] da, input logic [31:0] dwd,
    input logic [31:0] mr, input logic en, input logic we, input logic [5:0] ad,
    input logic [31:0] wd, input logic iak, input logic dak,
    input logic [31:0] ird, input logic [31:0] drd, input logic bz);
    vec_t v;
    v.rst = rs; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.mr = mr; v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_wdata = wd;
    v.e_iack = iak; v.e_dack = dak; v.e_ird = ird; v.e_drd = drd; v.e_busy = bz;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst  ir ia      dr dw da      dwd           mr             en we addr    wdata         ia da ird            drd            bz
    add(1, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 0 reset idle
    add(1, 1, 6'd5,  1, 1, 6'd3,  32'hDEADBEEF, 32'hFFFFFFFF,  0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 1 reset masks reqs
    add(0, 1, 6'd5,  0, 0, 6'd0,  32'd0,        32'd0,         1, 0, 6'd5,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 2 fetch grant
    add(0, 1, 6'd5,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 3 WAIT
    add(0, 1, 6'd5,  0, 0, 6'd0,  32'd0,        32'h12345678,  0, 0, 6'd0,  32'd0,        1, 0, 32'h12345678,  32'd0,         1); // 4 i_ack
    add(0, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 5 idle
    add(0, 0, 6'd0,  1, 1, 6'd3,  32'hDEADBEEF, 32'd0,         1, 1, 6'd3,  32'hDEADBEEF, 0, 0, 32'd0,         32'd0,         0); // 6 store grant
    add(0, 0, 6'd0,  1, 1, 6'd3,  32'hDEADBEEF, 32'h55555555,  0, 0, 6'd0,  32'd0,        0, 1, 32'd0,         32'd0,         1); // 7 store ack
    add(0, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 8 idle
    add(0, 0, 6'd0,  1, 0, 6'h2A, 32'd0,        32'd0,         1, 0, 6'h2A, 32'd0,        0, 0, 32'd0,         32'd0,         0); // 9 load grant
    add(0, 0, 6'd0,  1, 0, 6'h2A, 32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 10 WAIT
    add(0, 0, 6'd0,  1, 0, 6'h2A, 32'd0,        32'hCAFEF00D,  0, 0, 6'd0,  32'd0,        0, 1, 32'd0,         32'hCAFEF00D,  1); // 11 load ack
    add(0, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 12 idle
    add(1, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 13 reset
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         1, 0, 6'd9,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 14 conflict: D
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 15
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'h0000D001,  0, 0, 6'd0,  32'd0,        0, 1, 32'd0,         32'h0000D001,  1); // 16 d_ack
    add(0, 1, 6'd7,  0, 0, 6'd0,  32'd0,        32'd0,         1, 0, 6'd7,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 17 I granted
    add(0, 1, 6'd7,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 18
    add(0, 1, 6'd7,  0, 0, 6'd0,  32'd0,        32'h0000100A,  0, 0, 6'd0,  32'd0,        1, 0, 32'h0000100A,  32'd0,         1); // 19 i_ack
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         1, 0, 6'd9,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 20 alternate: D
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 21
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'h0000D002,  0, 0, 6'd0,  32'd0,        0, 1, 32'd0,         32'h0000D002,  1); // 22
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         1, 0, 6'd7,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 23 alternate: I
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 24
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'h0000100B,  0, 0, 6'd0,  32'd0,        1, 0, 32'h0000100B,  32'd0,         1); // 25
    add(0, 1, 6'd5,  0, 0, 6'd0,  32'd0,        32'd0,         1, 0, 6'd5,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 26 fetch grant
    add(1, 1, 6'd5,  0, 0, 6'd0,  32'd0,        32'h99999999,  0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 27 reset in WAIT
    add(0, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'h99999999,  0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 28 no ack, idle
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         1, 0, 6'd9,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 29 conflict: D
    add(1, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 30 reset aborts D
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         1, 0, 6'd9,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 31 D wins again
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 32
    add(0, 1, 6'd7,  1, 0, 6'd9,  32'd0,        32'h0000D003,  0, 0, 6'd0,  32'd0,        0, 1, 32'd0,         32'h0000D003,  1); // 33
    add(0, 1, 6'h11, 0, 0, 6'd0,  32'd0,        32'd0,         1, 0, 6'h11, 32'd0,        0, 0, 32'd0,         32'd0,         0); // 34 fetch grant
    add(0, 0, 6'd0,  1, 1, 6'h22, 32'hA5A5A5A5, 32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         1); // 35 late change ignored
    add(0, 0, 6'd0,  1, 1, 6'h22, 32'hA5A5A5A5, 32'h0BADF00D,  0, 0, 6'd0,  32'd0,        1, 0, 32'h0BADF00D,  32'd0,         1); // 36 fetch completes
    add(0, 0, 6'd0,  1, 1, 6'h22, 32'hA5A5A5A5, 32'd0,         1, 1, 6'h22, 32'hA5A5A5A5, 0, 0, 32'd0,         32'd0,         0); // 37 held d_req granted
    add(0, 0, 6'd0,  1, 1, 6'h22, 32'hA5A5A5A5, 32'h77777777,  0, 0, 6'd0,  32'd0,        0, 1, 32'd0,         32'd0,         1); // 38 store ack
    add(0, 0, 6'd0,  0, 0, 6'd0,  32'd0,        32'd0,         0, 0, 6'd0,  32'd0,        0, 0, 32'd0,         32'd0,         0); // 39 idle

    // Apply one vector per cycle: drive after the falling edge, check 1 ns later
    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst; i_req = vq[k].ir; i_addr = vq[k].ia;
      d_req = vq[k].dr; d_we = vq[k].dw; d_addr = vq[k].da; d_wdata = vq[k].dwd;
      mem_rdata = vq[k].mr;
      #1;
      chk("mem_en",  k, {31'd0, mem_en}, {31'd0, vq[k].e_en});
      chk("mem_we",  k, {31'd0, mem_we}, {31'd0, vq[k].e_we});
      chk("i_ack",   k, {31'd0, i_ack},  {31'd0, vq[k].e_iack});
      chk("d_ack",   k, {31'd0, d_ack},  {31'd0, vq[k].e_dack});
      chk("busy",    k, {31'd0, busy},   {31'd0, vq[k].e_busy});
      chk("i_rdata", k, i_rdata, vq[k].e_ird);
      chk("d_rdata", k, d_rdata, vq[k].e_drd);
      if (vq[k].e_en) chk("mem_addr", k, {26'd0, mem_addr}, {26'd0, vq[k].e_addr});
      if (vq[k].e_we) chk("mem_wdata", k, mem_wdata, vq[k].e_wdata);
    end

    // MEM_LAT=1: fetch request held high gives grant/ack on alternate cycles
    @(negedge clk);
    u1_rst = 1'b1; u1_i_req = 1'b0;
    #1;
    chk("lat1_reset_en", 100, {31'd0, u1_mem_en}, 32'd0);
    chk("lat1_reset_busy", 100, {31'd0, u1_busy}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      u1_rst = 1'b0; u1_i_req = 1'b1; u1_i_addr = 6'd3;
      u1_mem_rdata = 32'hB0000000 + 32'(k);
      #1;
      chk("lat1_mem_en", 200 + k, {31'd0, u1_mem_en}, {31'd0, ((k % 2) == 0)});
      chk("lat1_i_ack",  200 + k, {31'd0, u1_i_ack},  {31'd0, ((k % 2) == 1)});
      chk("lat1_busy",   200 + k, {31'd0, u1_busy},   {31'd0, ((k % 2) == 1)});
      chk("lat1_d_ack",  200 + k, {31'd0, u1_d_ack},  32'd0);
      if ((k % 2) == 1) begin
        chk("lat1_i_rdata", 200 + k, u1_i_rdata, 32'hB0000000 + 32'(k));
      end else begin
        chk("lat1_mem_addr", 200 + k, {26'd0, u1_mem_addr}, 32'd3);
      end
    end
    @(negedge clk);
    u1_i_req = 1'b0;
    #1;
    chk("lat1_idle_en", 300, {31'd0, u1_mem_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters:
REQ-001 The block SHALL provide parameter ADDR_W, default 6, the word-address width of the shared memory.
REQ-002 The block SHALL provide parameter MEM_LAT, default 2, the number of cycles from mem_en to valid mem_rdata for reads; legal range 1..15.

Ports:
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 i_req  in  1  fetch port read request, held until i_ack.
REQ-006 i_addr  in  ADDR_W  fetch word address, stable while i_req=1.
REQ-007 i_ack  out  1  one-cycle pulse that completes the fetch access.
REQ-008 i_rdata  out  32  fetch read data, valid only while i_ack=1.
REQ-009 d_req  in  1  data port request (load or store), held until d_ack.
REQ-010 d_we  in  1  1=store, 0=load; stable while d_req=1.
REQ-011 d_addr  in  ADDR_W  data word address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_ack  out  1  one-cycle pulse that completes the data access.
REQ-014 d_rdata  out  32  load data, valid only while d_ack=1.
REQ-015 mem_en  out  1  one-cycle access strobe to the single-port memory.
REQ-016 mem_we  out  1  write enable, qualified by mem_en.
REQ-017 mem_addr  out  ADDR_W  memory word address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have three states, IDLE, WAIT and DONE, plus a 1-bit last_grant register (I or D) and a latency counter of 4 bits.
REQ-022 The block SHALL sample requests only in IDLE; at most one access is outstanding at any time.
REQ-023 In IDLE with exactly one request, that port SHALL be granted.
REQ-024 In IDLE with both requests, the port not recorded in last_grant SHALL be granted (round-robin), and last_grant SHALL update to the winner.
REQ-025 In the grant cycle, mem_en=1 SHALL be driven combinationally, with mem_addr, mem_we (d_we for D, 0 for I) and mem_wdata taken from the granted port.
REQ-026 Outside the grant cycle, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-027 A store SHALL go from IDLE to DONE, so the ack is asserted 1 cycle after mem_en.
REQ-028 A load or fetch with MEM_LAT=1 SHALL go from IDLE to DONE; with MEM_LAT>1 it SHALL go to WAIT, stay there MEM_LAT-1 cycles, then go to DONE. The ack is therefore asserted exactly MEM_LAT cycles after mem_en.
REQ-029 In DONE, the block SHALL assert the granted port's ack for exactly one cycle, pass mem_rdata through to that port's rdata for reads, and return to IDLE unconditionally.
REQ-030 The non-granted port's ack SHALL stay 0 and its request SHALL remain pending untouched.
REQ-031 A request still asserted in the cycle after its ack SHALL be treated as a new request; requesters deassert req on the ack edge.
REQ-032 Throughput: one access per MEM_LAT+1 cycles for reads and one per 2 cycles for stores.
REQ-033 Request inputs that change while not in IDLE SHALL have no effect until the next IDLE cycle.

Reset
REQ-034 With rst=1 at a clock edge, the next state SHALL be IDLE, the counter 0, and last_grant=I (so D wins the first conflict).
REQ-035 While in reset, i_ack, d_ack, mem_en, mem_we and busy SHALL be 0; i_rdata and d_rdata SHALL be 0.
REQ-036 If rst is asserted during WAIT or DONE, the in-flight access SHALL be abandoned with no ack issued; the requester must reissue it.

Verification (MEM_LAT=2)
REQ-037 Single fetch: i_req=1 with i_addr=5 at T0 in IDLE -> mem_en=1, mem_addr=5, mem_we=0 at T0; i_ack=1 with i_rdata=mem_rdata at T2; busy=1 at T1..T2.
REQ-038 Store: d_req=1, d_we=1, d_addr=3, d_wdata=0xDEADBEEF at T0 -> mem_we=1 and mem_wdata=0xDEADBEEF at T0; d_ack at T1; IDLE at T2.
REQ-039 Conflict after reset: i_req and d_req both asserted at T0 -> D granted at T0 with d_ack at T2; I granted at T3 with i_ack at T5; the two grants alternate while both requests stay high.
REQ-040 Reset mid-access: fetch issued at T0, rst=1 at T1 -> no i_ack at T2; busy=0 from T2; the next conflict is won by D.
REQ-041 MEM_LAT=1 build: back-to-back fetches -> mem_en at T0, T2, T4 and i_ack at T1, T3, T5.
REQ-042 Late request change: i_req dropped and d_req raised during WAIT -> no effect until IDLE; a held d_req is then granted in the first IDLE cycle.
